mem_sequencer: RTL

Multi-cycle controller between the MIPS datapath and a single shared Avalon-style memory port. It time-multiplexes instruction fetch and data load/store onto one bus and tolerates `waitrequest` stalls. It holds fetched instruction and load data stable in registers, and produces the datapath `clk_enable` so that exactly one architectural step commits per instruction. It also detects halt (fetch from `HALT_ADDR`) and reports `active`.

---
 rtl/mem_sequencer_if.sv | 14 +
 rtl/mem_sequencer.sv | 66 ++++++
 2 files changed

// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: Avalon-style single memory port shared by instruction fetch and data access.
//   address/read/write/writedata/byteenable : master -> slave request
//   readdata/waitrequest                     : slave -> master response
interface mem_sequencer_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    modport master (output address, read, write, writedata, byteenable, input readdata, waitrequest);
    modport slave  (input address, read, write, writedata, byteenable, output readdata, waitrequest);
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: multi-cycle fetch/load/store sequencer onto one shared memory port.
//   clk, reset (sync, active-high)
//   instr_address/instr_readdata : PC in, registered instruction out
//   data_address/data_writedata/data_byteenable, mem_read_req/mem_write_req : data access request
//   data_readdata : registered load data; clk_enable : one-cycle commit; active : low once halted
//   avm : shared memory bus (master side)
module mem_sequencer #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic        active,
    mem_sequencer_if.master avm
);
    typedef enum logic [2:0] {FETCH, DECODE, DATA, COMMIT, HALT} state_t;
    state_t state, next;
    logic   is_write;
    logic   at_halt;
    logic   fetch_rd;
    logic   data_go;
    assign at_halt = instr_address == HALT_ADDR;
    // Strobes are masked while reset is high so no access starts before release.
    assign fetch_rd = state == FETCH && !at_halt && !reset;
    assign data_go  = state == DATA && !reset;
    assign avm.read       = fetch_rd || (data_go && !is_write);
    assign avm.write      = data_go && is_write;
    assign avm.address    = (state == DATA ? data_address : instr_address) & ~32'd3;
    assign avm.byteenable = state == DATA ? data_byteenable : 4'hf;
    assign avm.writedata  = data_writedata;
    assign clk_enable     = state == COMMIT && !reset;
    assign active         = state != HALT;
    always_comb begin
        next = state;
        case (state)
            FETCH:   next = at_halt ? HALT : (avm.waitrequest ? FETCH : DECODE);
            DECODE:  next = (mem_read_req || mem_write_req) ? DATA : COMMIT;
            DATA:    next = avm.waitrequest ? DATA : COMMIT;
            COMMIT:  next = FETCH;
            HALT:    next = HALT;
            default: next = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FETCH;
            is_write       <= 1'b0;
            instr_readdata <= '0;
            data_readdata  <= '0;
        end else begin
            state <= next;
            // Direction is frozen here; a write request wins when both are raised.
            if (state == DECODE) is_write <= mem_write_req;
            if (fetch_rd && !avm.waitrequest) instr_readdata <= avm.readdata;
            if (data_go && !is_write && !avm.waitrequest) data_readdata <= avm.readdata;
        end
    end
endmodule
